// File: rtl/usb_device_line_driver.sv
// Device-side USB line-state transmitter: drives J on attach, then K for
// remote-wakeup resume or SE0/SE0/J for end-of-packet, on request from link control.
module usb_device_line_driver #(
    parameter int ATTACH_CYCLES   = 16,
    parameter int RESUME_CYCLES   = 32,
    parameter int FS_CLKS_PER_BIT = 4,
    parameter int LS_CLKS_PER_BIT = 32,
    parameter int CNT_W           = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       attach,
    input  logic       speed_low,
    input  logic       resume_req,
    input  logic       eop_req,
    output logic [1:0] usb_signals,
    output logic       usb_oe,
    output logic       connected,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        ST_DETACHED = 3'd0,
        ST_ATTACH   = 3'd1,
        ST_IDLE     = 3'd2,
        ST_RESUME   = 3'd3,
        ST_EOP_SE0  = 3'd4,
        ST_EOP_J    = 3'd5
    } state_t;

    localparam logic [1:0] LINE_SE0 = 2'b00;

    // Counter loads are "cycles - 1" so that the zero check ends each phase exactly on time.
    localparam logic [CNT_W-1:0] ATT_LOAD    = CNT_W'(ATTACH_CYCLES - 1);
    localparam logic [CNT_W-1:0] RES_LOAD    = CNT_W'(RESUME_CYCLES - 1);
    localparam logic [CNT_W-1:0] FS_SE0_LOAD = CNT_W'(2 * FS_CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] LS_SE0_LOAD = CNT_W'(2 * LS_CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] FS_J_LOAD   = CNT_W'(FS_CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] LS_J_LOAD   = CNT_W'(LS_CLKS_PER_BIT - 1);

    function automatic logic [1:0] j_code(input logic spd_low);
        return spd_low ? 2'b01 : 2'b10;
    endfunction

    function automatic logic [1:0] k_code(input logic spd_low);
        return spd_low ? 2'b10 : 2'b01;
    endfunction

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_spd;
    logic [1:0]         r_sig;
    logic               r_oe;
    logic               r_conn;
    logic               r_busy;
    logic               r_done;

    logic               w_cnt_zero;
    logic [CNT_W-1:0]   w_se0_load;
    logic [CNT_W-1:0]   w_j_load;
    logic [CNT_W-1:0]   w_cnt_dec;

    assign w_cnt_zero = (r_cnt == {CNT_W{1'b0}});
    assign w_se0_load = r_spd ? LS_SE0_LOAD : FS_SE0_LOAD;
    assign w_j_load   = r_spd ? LS_J_LOAD : FS_J_LOAD;
    // Saturating decrement: the counter stops at zero rather than wrapping.
    assign w_cnt_dec  = w_cnt_zero ? r_cnt : (r_cnt - {{(CNT_W-1){1'b0}}, 1'b1});

    // Line-state FSM with all outputs registered alongside the state.
    always_ff @(posedge clock) begin
        if (reset || !attach) begin
            r_state <= ST_DETACHED;
            r_cnt   <= {CNT_W{1'b0}};
            r_spd   <= reset ? 1'b0 : r_spd;
            r_sig   <= LINE_SE0;
            r_oe    <= 1'b0;
            r_conn  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_DETACHED: begin
                    r_state <= ST_ATTACH;
                    r_spd   <= speed_low;
                    r_cnt   <= ATT_LOAD;
                    r_sig   <= j_code(speed_low);
                    r_oe    <= 1'b1;
                    r_conn  <= 1'b0;
                    r_busy  <= 1'b1;
                end
                ST_ATTACH: begin
                    if (w_cnt_zero) begin
                        r_state <= ST_IDLE;
                        r_conn  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= w_cnt_dec;
                    end
                end
                ST_IDLE: begin
                    // Resume has priority; a simultaneous EOP request is dropped.
                    if (resume_req) begin
                        r_state <= ST_RESUME;
                        r_cnt   <= RES_LOAD;
                        r_sig   <= k_code(r_spd);
                        r_busy  <= 1'b1;
                    end else if (eop_req) begin
                        r_state <= ST_EOP_SE0;
                        r_cnt   <= w_se0_load;
                        r_sig   <= LINE_SE0;
                        r_busy  <= 1'b1;
                    end else begin
                        r_sig  <= j_code(r_spd);
                        r_busy <= 1'b0;
                    end
                end
                ST_RESUME: begin
                    if (w_cnt_zero) begin
                        r_state <= ST_IDLE;
                        r_sig   <= j_code(r_spd);
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_dec;
                    end
                end
                ST_EOP_SE0: begin
                    if (w_cnt_zero) begin
                        r_state <= ST_EOP_J;
                        r_cnt   <= w_j_load;
                        r_sig   <= j_code(r_spd);
                    end else begin
                        r_cnt <= w_cnt_dec;
                    end
                end
                ST_EOP_J: begin
                    if (w_cnt_zero) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_dec;
                    end
                end
                default: begin
                    r_state <= ST_DETACHED;
                    r_cnt   <= {CNT_W{1'b0}};
                    r_sig   <= LINE_SE0;
                    r_oe    <= 1'b0;
                    r_conn  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign usb_signals = r_sig;
    assign usb_oe      = r_oe;
    assign connected   = r_conn;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule

// File: tb/tb_usb_device_line_driver.sv
// Randomized bench for usb_device_line_driver; expected outputs come from a
// schedule-queue model of the line activity.
module tb_usb_device_line_driver;

    localparam int ATT = 16;
    localparam int RES = 32;
    localparam int FSB = 4;
    localparam int LSB = 32;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       attach = 1'b0;
    logic       speed_low = 1'b0;
    logic       resume_req = 1'b0;
    logic       eop_req = 1'b0;
    logic [1:0] usb_signals;
    logic       usb_oe, connected, busy, done;

    int n_checks = 0;
    int n_errs   = 0;

    usb_device_line_driver #(
        .ATTACH_CYCLES(ATT), .RESUME_CYCLES(RES),
        .FS_CLKS_PER_BIT(FSB), .LS_CLKS_PER_BIT(LSB), .CNT_W(16)
    ) dut (
        .clock(clock), .reset(reset), .attach(attach), .speed_low(speed_low),
        .resume_req(resume_req), .eop_req(eop_req), .usb_signals(usb_signals),
        .usb_oe(usb_oe), .connected(connected), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    // Model: a queue of upcoming output cycles; an empty queue while attached means IDLE.
    typedef struct packed {
        logic [1:0] sig;
        logic       bsy;
        logic       con;
    } ent_t;

    ent_t       sched[$];
    bit         m_att = 0, m_spd = 0, m_idle = 0, m_seq = 0;
    logic [1:0] e_sig = 2'b00;
    logic       e_oe = 1'b0, e_conn = 1'b0, e_busy = 1'b0, e_done = 1'b0;

    function automatic logic [1:0] j_of(input bit s);
        return s ? 2'b01 : 2'b10;
    endfunction

    function automatic logic [1:0] k_of(input bit s);
        return s ? 2'b10 : 2'b01;
    endfunction

    task automatic push_n(input int n, input logic [1:0] s, input logic b, input logic c);
        ent_t e;
        e.sig = s; e.bsy = b; e.con = c;
        for (int i = 0; i < n; i++) sched.push_back(e);
    endtask

    task automatic model_edge();
        ent_t e;
        int   bit_clks;
        if (reset || !attach) begin
            sched.delete();
            m_att = 0; m_idle = 0; m_seq = 0;
            e_sig = 2'b00; e_oe = 1'b0; e_conn = 1'b0; e_busy = 1'b0; e_done = 1'b0;
        end else begin
            e_done = 1'b0;
            if (!m_att) begin
                m_att = 1; m_spd = speed_low; m_seq = 0;
                push_n(ATT, j_of(m_spd), 1'b1, 1'b0);
            end else if (m_idle && resume_req) begin
                push_n(RES, k_of(m_spd), 1'b1, 1'b1);
                m_seq = 1;
            end else if (m_idle && eop_req) begin
                bit_clks = m_spd ? LSB : FSB;
                push_n(2 * bit_clks, 2'b00, 1'b1, 1'b1);
                push_n(bit_clks, j_of(m_spd), 1'b1, 1'b1);
                m_seq = 1;
            end
            if (sched.size() > 0) begin
                e = sched.pop_front();
                e_sig = e.sig; e_busy = e.bsy; e_conn = e.con;
                m_idle = 0;
            end else begin
                e_sig = j_of(m_spd); e_busy = 1'b0; e_conn = 1'b1;
                e_done = m_seq; m_seq = 0;
                m_idle = 1;
            end
            e_oe = 1'b1;
        end
    endtask

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        check_eq("usb_signals", 32'(usb_signals), 32'(e_sig));
        check_eq("usb_oe", 32'(usb_oe), 32'(e_oe));
        check_eq("connected", 32'(connected), 32'(e_conn));
        check_eq("busy", 32'(busy), 32'(e_busy));
        check_eq("done", 32'(done), 32'(e_done));
        check_eq("done_with_busy", 32'(done & busy), 32'd0);
    endtask

    int cnt_a, cnt_b, cnt_c, first_conn;

    initial begin
        // 1: reset, full-speed attach, 16-cycle ATTACH
        step(); step();
        reset = 1'b0; attach = 1'b1; speed_low = 1'b0;
        cnt_a = 0; first_conn = -1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (busy) cnt_a++;
            if (connected && first_conn < 0) first_conn = i;
            if (i == 0) check_eq("attach_j_fs", 32'(usb_signals), 32'h2);
        end
        check_eq("attach_busy_cycles", 32'(cnt_a), 32'd16);
        check_eq("attach_first_connected", 32'(first_conn), 32'd16);

        // 3: full-speed EOP timing
        eop_req = 1'b1; step(); eop_req = 1'b0;
        cnt_a = (usb_signals == 2'b00) ? 1 : 0; cnt_b = 0; cnt_c = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (usb_signals == 2'b00) cnt_a++;
            if (busy && usb_signals == 2'b10) cnt_b++;
            if (done) cnt_c++;
        end
        check_eq("eop_se0_cycles", 32'(cnt_a), 32'd8);
        check_eq("eop_j_cycles", 32'(cnt_b), 32'd4);
        check_eq("eop_done_pulses", 32'(cnt_c), 32'd1);

        // 4: simultaneous requests -> resume only
        resume_req = 1'b1; eop_req = 1'b1; step(); resume_req = 1'b0; eop_req = 1'b0;
        cnt_a = (usb_signals == 2'b01) ? 1 : 0; cnt_b = 0;
        for (int i = 0; i < 45; i++) begin
            step();
            if (usb_signals == 2'b01) cnt_a++;
            if (usb_signals == 2'b00) cnt_b++;
        end
        check_eq("both_req_k_cycles", 32'(cnt_a), 32'd32);
        check_eq("both_req_no_eop", 32'(cnt_b), 32'd0);

        // 5: detach during SE0, then eop while detached
        eop_req = 1'b1; step(); eop_req = 1'b0;
        step(); step();
        attach = 1'b0; step();
        check_eq("detach_oe", 32'(usb_oe), 32'd0);
        eop_req = 1'b1; step(); eop_req = 1'b0;
        for (int i = 0; i < 4; i++) step();

        // 2: low-speed attach, speed toggling ignored, resume
        attach = 1'b1; speed_low = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            speed_low = ~speed_low;
        end
        check_eq("ls_idle_j", 32'(usb_signals), 32'h1);
        resume_req = 1'b1; step(); resume_req = 1'b0;
        for (int i = 0; i < 36; i++) begin
            step();
            speed_low = ~speed_low;
        end

        // 6: reset during resume, then full re-attach
        resume_req = 1'b1; step(); resume_req = 1'b0;
        for (int i = 0; i < 5; i++) step();
        reset = 1'b1; step();
        check_eq("reset_mid_resume_sig", 32'(usb_signals), 32'h0);
        reset = 1'b0; speed_low = 1'b0;
        cnt_a = 0;
        for (int i = 0; i < 18; i++) begin
            step();
            if (busy) cnt_a++;
        end
        check_eq("reattach_busy_cycles", 32'(cnt_a), 32'd16);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            reset      = ($urandom_range(0, 599) == 0);
            attach     = ($urandom_range(0, 249) != 0);
            speed_low  = 1'($urandom_range(0, 1));
            resume_req = ($urandom_range(0, 29) == 0);
            eop_req    = ($urandom_range(0, 19) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
